uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- It is the receive-side counterpart of the team's UART transmitter. Both use the same CLK_DIV, so one bit period is CLK_DIV+1 clk cycles.
- Samples an asynchronous serial line and presents each received byte through a valid/ack handshake.
- Flags framing errors and overruns.

Parameters:
- CLK_DIV, 434, bit period minus one. BIT = CLK_DIV+1 clk cycles per bit; HALF = BIT/2 (floor).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idle high.
- rx_ack  in  1  consumer acknowledge; clears rx_valid.
- rx_data  out  8  last accepted byte.
- rx_valid  out  1  level; high while rx_data holds an unacknowledged byte.
- rx_busy  out  1  high while a frame is being received (any state other than IDLE).
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while rx_valid was still high.

Behaviour:
- Reset (rst=1 at a clk edge): rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, synchroniser flops=1, state=IDLE, counters=0. Reset mid-frame abandons the frame.
- Synchroniser: rx passes through 2 flops before any use; rx_s is the second flop.
- The bit counter counts clk cycles 0..BIT-1. The bit index counts 0..7.
- IDLE: on rx_s==0, go to START and clear the cycle counter.
- START: after HALF cycles, sample rx_s.
  - 0 -> DATA; cycle counter=0; bit index=0.
  - 1 -> false start; return to IDLE; no outputs change.
- DATA: every BIT cycles, sample rx_s into the shift register at the bit index (LSB first). After bit 7 -> STOP.
- STOP: BIT cycles after the bit-7 sample, sample rx_s.
  - 1 (good frame): go to IDLE next cycle.
    - If rx_valid==0 or rx_ack==1 in that cycle: rx_data <= shift register, rx_valid <= 1.
    - Otherwise: overrun pulses 1 cycle, rx_data keeps the old byte, and the new byte is dropped.
  - 0 (framing error): frame_err pulses 1 cycle; rx_data and rx_valid are unchanged. Go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. A held-low line does not retrigger a start.
- rx_ack: when rx_ack==1 and rx_valid==1, clear rx_valid next cycle, unless a new byte is loaded in the same cycle (then rx_valid stays 1 with the new data). rx_ack while rx_valid==0 is ignored.
- Latency: the first low cycle on rx arrives at rx_s 2 cycles later. The stop sample occurs HALF + 9*BIT cycles after rx_s falls. rx_valid rises 1 cycle after the stop sample.
- Sampling lands at mid-bit; a tolerated baud mismatch of ≤ ±2% holds for CLK_DIV ≥ 15.
- Glitch rejection: a low pulse shorter than HALF cycles is rejected by the START check.
- Back-to-back frames: a new start edge is accepted on the first IDLE cycle after the stop sample, so stop-to-start with zero idle bits is supported.
- Widths: the cycle counter is wide enough for CLK_DIV (clog2(CLK_DIV+1) bits). No wrap occurs beyond BIT-1.

Test Plan (CLK_DIV=15, BIT=16, HALF=8; tolerance on edge timing ±1 cycle):
- Drive frame 0xA5, no ack -> rx_valid rises about 2+8+144+1 cycles after rx falls; rx_data=0xA5; frame_err=0; overrun=0; rx_busy returns 0.
- Drive rx low for 4 cycles, then high -> START rejects; no rx_valid, no frame_err; rx_busy high for under 12 cycles then 0. A following frame 0x5A is received correctly.
- Drive 0x3C with stop bit=0, line held low 40 cycles, then high -> single frame_err pulse; rx_valid stays 0; no new start until the line returns high. The next frame 0x01 is received.
- Drive 0x11 then 0x22 back-to-back, no ack -> rx_valid=1, rx_data=0x11, one overrun pulse at 0x22's stop sample. Assert rx_ack -> rx_valid=0. Drive 0x33 -> rx_data=0x33.
- Hold rx_valid with 0x44, pulse rx_ack in the exact cycle of 0x55's stop completion -> no overrun; rx_valid stays 1; rx_data=0x55.
- Assert rst during data bit 4 of 0xF0 -> all outputs reset values next cycle. Release, drive 0x0F -> rx_data=0x0F.
- Loopback with the transmitter for bytes 0x00, 0xFF, 0x80, 0x01 -> each received byte matches, with no errors.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus received-byte handshake of the UART receiver.
//   rx        serial input, idle high
//   rx_ack    consumer acknowledge
//   rx_data   last accepted byte
//   rx_valid  level, unacknowledged byte present
//   rx_busy   frame in progress
//   frame_err one-cycle pulse, stop bit sampled low
//   overrun   one-cycle pulse, byte dropped because rx_valid was still high
// master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_if;
   logic       rx;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;

   modport master (
      input  rx, rx_ack,
      output rx_data, rx_valid, rx_busy, frame_err, overrun
   );

   modport slave (
      output rx, rx_ack,
      input  rx_data, rx_valid, rx_busy, frame_err, overrun
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. One bit period is CLK_DIV+1 clk cycles.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  uart_rx_if.master (rx in, rx_ack in, rx_data/rx_valid/rx_busy/
//        frame_err/overrun out)
// Bits are sampled mid-period: the start bit is re-checked HALF cycles after
// the falling edge, then every BIT cycles after that.
module uart_rx #(
   parameter int CLK_DIV = 434
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.master bus
);
   localparam int BIT = CLK_DIV + 1;
   localparam int HALF = BIT / 2;
   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          rx_s;

   assign rx_s = sync_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sync_q      <= 2'b11;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sync_d      = {sync_q[0], bus.rx};
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      // Ack clears the level; a byte loaded below in the same cycle wins.
      if (bus.rx_ack) rx_valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               idx_d = '0;
               // Line back high at mid-start: glitch, drop it silently.
               state_d = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = IDLE;
                  if (!rx_valid_q || bus.rx_ack) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BRK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         BRK: begin
            // Held-low line must return high before a new start is armed.
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.rx_busy   = (state_q != IDLE);
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
endmodule
